// File: rtl/gates_checker_pkg.sv
// Shared definitions for the gates checker: FSM encoding, vector table and
// output bit positions of the two-input gates block.
package gates_checker_pkg;

    // Checker FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StSample = 2'd2,
        StDone   = 2'd3
    } state_e;

    // Number of vectors in one sweep
    localparam int unsigned NumVec = 4;

    // Vector table indexed by idx: (a,b) = (1,1), (0,1), (1,0), (0,0)
    localparam logic [NumVec-1:0] VecA = 4'b0101;
    localparam logic [NumVec-1:0] VecB = 4'b0011;

    // Bit positions of the gate outputs inside y[4:0]
    localparam int unsigned YAnd  = 0;
    localparam int unsigned YOr   = 1;
    localparam int unsigned YXor  = 2;
    localparam int unsigned YNand = 3;
    localparam int unsigned YNor  = 4;

    // Look up the (a,b) pair driven for a given vector index
    function automatic logic [1:0] vec_ab(input logic [1:0] idx);
        return {VecA[idx], VecB[idx]};
    endfunction

endpackage

// File: rtl/gates_ref.sv
// Golden combinational model of the two-input gates block.
module gates_ref
    import gates_checker_pkg::*;
(
    input  logic       a,
    input  logic       b,
    output logic [4:0] y_exp
);

    // Expected value of every gate output for the current inputs
    always_comb begin
        y_exp        = '0;
        y_exp[YAnd]  = a & b;
        y_exp[YOr]   = a | b;
        y_exp[YXor]  = a ^ b;
        y_exp[YNand] = ~(a & b);
        y_exp[YNor]  = ~(a | b);
    end

endmodule

// File: rtl/gates_checker.sv
// On-board response checker for the gates block: sweeps the four input
// vectors, waits SETTLE_CYCLES per vector, compares y against the golden
// model and reports pass, error count and a per-vector fail mask.
module gates_checker
    import gates_checker_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 20,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic [4:0] y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    // Settle counter value on the last cycle a vector is held before sampling
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0]       IdxLast = 2'(NumVec - 1);

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             busy_q, busy_d;
    logic             pass_q, pass_d;
    logic [2:0]       err_q, err_d;
    logic [3:0]       fail_q, fail_d;

    logic [4:0]       y_exp;
    logic             mismatch;
    logic [1:0]       idx_next;

    // Golden outputs for the vector currently driven on a/b
    gates_ref u_gates_ref (
        .a     (a_q),
        .b     (b_q),
        .y_exp (y_exp)
    );

    assign mismatch = (y != y_exp);
    assign idx_next = idx_q + 2'd1;

    // Next-state and datapath updates of the sweep FSM
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    {a_d, b_d} = vec_ab(2'd0);
                    idx_d      = 2'd0;
                    cnt_d      = '0;
                    err_d      = '0;
                    fail_d     = '0;
                    pass_d     = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q == CntLast) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSample: begin
                if (mismatch) begin
                    // At most four vectors, so the 3-bit count never wraps
                    err_d         = err_q + 3'd1;
                    fail_d[idx_q] = 1'b1;
                end
                if (idx_q == IdxLast) begin
                    state_d = StDone;
                end else begin
                    idx_d      = idx_next;
                    {a_d, b_d} = vec_ab(idx_next);
                    cnt_d      = '0;
                    state_d    = StSettle;
                end
            end
            StDone: begin
                pass_d  = (err_q == 3'd0);
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and result registers; reset abandons any sweep in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = (state_q == StDone);
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gates_checker.sv
// Bench for gates_checker: two instances (S=20 and S=1) drive a behavioural
// gates block with selectable faults; a cycle-based expectation model is
// compared every cycle, plus literal checks of latency and sweep results.
module tb_gates_checker;

    logic       clk;
    logic       rst_n;
    logic [1:0] start_v;
    logic [1:0] a_v, b_v, busy_v, done_v, pass_v;
    logic [4:0] y_v   [2];
    logic [2:0] err_v [2];
    logic [3:0] fail_v[2];
    int         fault_v[2];

    int total;
    int bad;

    // Model state per instance: sweep ever started, edges since acceptance, fault used
    bit m_started[2];
    int m_n[2];
    int m_f[2];

    gates_checker #(.SETTLE_CYCLES(20), .CNT_W(8)) u_dut20 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_v[0]),
        .a         (a_v[0]),
        .b         (b_v[0]),
        .y         (y_v[0]),
        .busy      (busy_v[0]),
        .done      (done_v[0]),
        .pass      (pass_v[0]),
        .err_count (err_v[0]),
        .fail_vec  (fail_v[0])
    );

    gates_checker #(.SETTLE_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_v[1]),
        .a         (a_v[1]),
        .b         (b_v[1]),
        .y         (y_v[1]),
        .busy      (busy_v[1]),
        .done      (done_v[1]),
        .pass      (pass_v[1]),
        .err_count (err_v[1]),
        .fail_vec  (fail_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int s_of(input int i);
        return (i == 0) ? 20 : 1;
    endfunction

    // Gates block under test: 0 correct, 1 y3 stuck at 0, 2 y5 tied to y2
    function automatic logic [4:0] gates_y(input int f, input logic a, input logic b);
        logic [4:0] y;
        y = {~(a | b), ~(a & b), a ^ b, a | b, a & b};
        if (f == 1) y[2] = 1'b0;
        if (f == 2) y[4] = y[1];
        return y;
    endfunction

    assign y_v[0] = gates_y(fault_v[0], a_v[0], b_v[0]);
    assign y_v[1] = gates_y(fault_v[1], a_v[1], b_v[1]);

    // Truth table {y5,y4,y3,y2,y1} per vector index
    function automatic logic [4:0] gold(input int k);
        case (k)
            0:       return 5'b00011;
            1:       return 5'b01110;
            2:       return 5'b01110;
            default: return 5'b11000;
        endcase
    endfunction

    function automatic logic vec_a(input int k);
        return (k == 0) || (k == 2);
    endfunction

    function automatic logic vec_b(input int k);
        return (k == 0) || (k == 1);
    endfunction

    // Expected {a,b,busy,done,pass,err[2:0],fail[3:0]} n edges after acceptance
    function automatic logic [11:0] expect_out(input int s, input int f, input bit started,
                                               input int n);
        int         k;
        int         last;
        logic [2:0] err;
        logic [3:0] fail;
        logic       ea, eb, ebusy, edone, epass;
        if (!started) return 12'd0;
        last = 4 * (s + 1);
        k = n / (s + 1);
        if (k > 3) k = 3;
        ea    = vec_a(k);
        eb    = vec_b(k);
        ebusy = (n <= last);
        edone = (n == last);
        err   = 3'd0;
        fail  = 4'd0;
        for (int j = 0; j < 4; j++) begin
            if ((j + 1) * (s + 1) <= n && gates_y(f, vec_a(j), vec_b(j)) != gold(j)) begin
                err     = err + 3'd1;
                fail[j] = 1'b1;
            end
        end
        epass = (n >= last + 1) && (err == 3'd0);
        return {ea, eb, ebusy, edone, epass, err, fail};
    endfunction

    // Model time base: acceptance only when idle, reset abandons the sweep
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_started[i] <= 1'b0;
                m_n[i]       <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (start_v[i] && (!m_started[i] || m_n[i] >= 4 * (s_of(i) + 1) + 1)) begin
                    m_started[i] <= 1'b1;
                    m_n[i]       <= 0;
                    m_f[i]       <= fault_v[i];
                end else if (m_started[i] && m_n[i] < 4 * (s_of(i) + 1) + 2) begin
                    m_n[i] <= m_n[i] + 1;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [11:0] exp_v;
            logic [11:0] act_v;
            exp_v = expect_out(s_of(i), m_f[i], m_started[i], m_n[i]);
            act_v = {a_v[i], b_v[i], busy_v[i], done_v[i], pass_v[i], err_v[i], fail_v[i]};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL cycle_model inst=%0d t=%0t got=%b want=%b", i, $time, act_v,
                         exp_v);
            end
        end
    end

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
        end
    endtask

    // One sweep on instance i; caller is 1 time unit after a rising edge
    task automatic sweep(input int i, input int f, input bit repulse, input int exp_lat,
                         input logic [2:0] exp_err, input logic [3:0] exp_fail,
                         input logic exp_pass);
        int cnt;
        fault_v[i] = f;
        start_v[i] = 1'b1;
        @(posedge clk);
        #1;
        start_v[i] = 1'b0;
        check("cleared", {3'b0, busy_v[i], pass_v[i], err_v[i], fail_v[i]},
              {3'b0, 1'b1, 1'b0, 3'd0, 4'd0});
        cnt = 0;
        while (!done_v[i] && cnt < 300) begin
            @(posedge clk);
            #1;
            cnt++;
            start_v[i] = repulse && (cnt == 5 || cnt == 50);
        end
        start_v[i] = 1'b0;
        check("done_latency", 12'(cnt), 12'(exp_lat));
        @(posedge clk);
        #1;
        check("result", {3'b0, busy_v[i], pass_v[i], err_v[i], fail_v[i]},
              {3'b0, 1'b0, exp_pass, exp_err, exp_fail});
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        start_v    = 2'b00;
        fault_v[0] = 0;
        fault_v[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_inst0", {a_v[0], b_v[0], busy_v[0], done_v[0], pass_v[0], err_v[0],
              fail_v[0]}, 12'd0);
        check("reset_inst1", {a_v[1], b_v[1], busy_v[1], done_v[1], pass_v[1], err_v[1],
              fail_v[1]}, 12'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        sweep(0, 0, 1'b0, 84, 3'd0, 4'b0000, 1'b1);
        sweep(0, 1, 1'b0, 84, 3'd2, 4'b0110, 1'b0);
        sweep(0, 2, 1'b0, 84, 3'd4, 4'b1111, 1'b0);
        sweep(0, 0, 1'b1, 84, 3'd0, 4'b0000, 1'b1);

        // Reset 30 cycles into a sweep: vector 1 (0,1) is on the outputs then
        fault_v[0] = 0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("mid_sweep_vec1", {10'b0, a_v[0], b_v[0]}, 12'b01);
        rst_n = 1'b0;
        #2;
        check("mid_sweep_reset", {a_v[0], b_v[0], busy_v[0], done_v[0], pass_v[0], err_v[0],
              fail_v[0]}, 12'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sweep(0, 0, 1'b0, 84, 3'd0, 4'b0000, 1'b1);

        // S=1: faulty sweep then a back-to-back clean sweep
        sweep(1, 2, 1'b0, 8, 3'd4, 4'b1111, 1'b0);
        sweep(1, 0, 1'b0, 8, 3'd0, 4'b0000, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
